// File: rtl/vga_pkg.sv
// vga_pkg: shared constants, register map and state encoding for the
// rectangle fill engine and its raster scanner.
package vga_pkg;

  localparam int unsigned FB_W_DEFAULT = 160;
  localparam int unsigned FB_H_DEFAULT = 120;
  localparam int unsigned FB_ADDR_W    = 15;
  localparam int unsigned X_W          = 8;
  localparam int unsigned Y_W          = 7;

  // Register offsets from the block's base address
  localparam logic [2:0] REG_X0     = 3'd0;
  localparam logic [2:0] REG_Y0     = 3'd1;
  localparam logic [2:0] REG_X1     = 3'd2;
  localparam logic [2:0] REG_Y1     = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam logic [7:0] REG_COUNT  = 8'd6;

  // CTRL bit positions
  localparam int unsigned CTRL_START  = 7;
  localparam int unsigned CTRL_ABORT  = 6;
  localparam int unsigned CTRL_COLOUR = 0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FILL
  } state_t;

  // Saturate an X coordinate at the last column
  function automatic logic [X_W-1:0] clamp_x(input logic [7:0] v, input logic [7:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Saturate a Y coordinate at the last row; result always fits the Y counter
  function automatic logic [Y_W-1:0] clamp_y(input logic [7:0] v, input logic [7:0] lim);
    return Y_W'((v > lim) ? lim : v);
  endfunction

endpackage

// File: rtl/vga_xy_scanner.sv
// vga_xy_scanner: loadable X/Y raster counter. X is the inner loop; at X_MAX
// it wraps to X_MIN and Y advances. LAST flags the (X_MAX, Y_MAX) pixel and
// the counter holds there, so it never walks past the loaded bounds.
module vga_xy_scanner
  import vga_pkg::*;
(
  input  logic           CLK,
  input  logic           RESET,
  input  logic           LOAD,
  input  logic           STEP,
  input  logic [X_W-1:0] X_MIN,
  input  logic [X_W-1:0] X_MAX,
  input  logic [Y_W-1:0] Y_MIN,
  input  logic [Y_W-1:0] Y_MAX,
  output logic [X_W-1:0] CUR_X,
  output logic [Y_W-1:0] CUR_Y,
  output logic           LAST
);

  logic [X_W-1:0] x_min_q;
  logic [X_W-1:0] x_max_q;
  logic [Y_W-1:0] y_max_q;

  assign LAST = (CUR_X == x_max_q) && (CUR_Y == y_max_q);

  // Bound latch on load, raster advance on step
  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_min_q <= '0;
      x_max_q <= '0;
      y_max_q <= '0;
      CUR_X   <= '0;
      CUR_Y   <= '0;
    end else if (LOAD) begin
      x_min_q <= X_MIN;
      x_max_q <= X_MAX;
      y_max_q <= Y_MAX;
      CUR_X   <= X_MIN;
      CUR_Y   <= Y_MIN;
    end else if (STEP && !LAST) begin
      if (CUR_X == x_max_q) begin
        CUR_X <= x_min_q;
        CUR_Y <= CUR_Y + 1'b1;
      end else begin
        CUR_X <= CUR_X + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_rect_fill.sv
// vga_rect_fill: bus-mapped rectangle fill/clear engine. The CPU programs two
// corners and a colour, then starts a fill; one pixel write per cycle is
// streamed to the frame buffer in raster order.
// Optional: define VGA_FILL_IRQ_EN to add BUS_INTERRUPT_RAISE/BUS_INTERRUPT_ACK.
module vga_rect_fill
  import vga_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'hB4,
  parameter int unsigned FB_W      = FB_W_DEFAULT,
  parameter int unsigned FB_H      = FB_H_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RESET,
  inout  logic [7:0]           BUS_DATA,
  input  logic [7:0]           BUS_ADDR,
  input  logic                 BUS_WE,
  output logic [FB_ADDR_W-1:0] FB_ADDR,
  output logic                 FB_DATA,
  output logic                 FB_WE,
  output logic                 BUSY
`ifdef VGA_FILL_IRQ_EN
  ,
  output logic                 BUS_INTERRUPT_RAISE,
  input  logic                 BUS_INTERRUPT_ACK
`endif
);

  localparam logic [7:0] X_LIM = 8'(FB_W - 1);
  localparam logic [7:0] Y_LIM = 8'(FB_H - 1);

  logic [7:0]     x0_q, y0_q, x1_q, y1_q;
  logic           colour_q;
  logic           fill_colour_q;
  logic           done_q;
  logic           done_set;
  logic           rd_en_q;
  logic [7:0]     rd_data_q;
  state_t         state_q, state_d;

  logic [7:0]     offset;
  logic           in_range, reg_wr, rd_sel, ctrl_wr, start_req, abort_req;

  logic [X_W-1:0] xa, xb, x_min, x_max;
  logic [Y_W-1:0] ya, yb, y_min, y_max;
  logic [X_W-1:0] cur_x;
  logic [Y_W-1:0] cur_y;
  logic           last_px;

  // Address decode; the subtraction wraps, so addresses below the base fall out of range
  assign offset    = BUS_ADDR - BASE_ADDR;
  assign in_range  = offset < REG_COUNT;
  assign reg_wr    = in_range && BUS_WE;
  assign rd_sel    = in_range && !BUS_WE;
  assign ctrl_wr   = reg_wr && (offset[2:0] == REG_CTRL);
  assign abort_req = ctrl_wr && BUS_DATA[CTRL_ABORT];
  assign start_req = ctrl_wr && BUS_DATA[CTRL_START] && !BUS_DATA[CTRL_ABORT];

  // Clamp each corner first, then order them; equivalent to clamping the ordered pair
  assign xa    = clamp_x(x0_q, X_LIM);
  assign xb    = clamp_x(x1_q, X_LIM);
  assign ya    = clamp_y(y0_q, Y_LIM);
  assign yb    = clamp_y(y1_q, Y_LIM);
  assign x_min = (xa < xb) ? xa : xb;
  assign x_max = (xa < xb) ? xb : xa;
  assign y_min = (ya < yb) ? ya : yb;
  assign y_max = (ya < yb) ? yb : ya;

  assign BUSY    = (state_q != IDLE);
  assign FB_WE   = (state_q == FILL);
  assign FB_ADDR = {cur_y, cur_x};
  assign FB_DATA = fill_colour_q;

  assign BUS_DATA = rd_en_q ? rd_data_q : 'z;

  vga_xy_scanner u_scanner (
    .CLK   (CLK),
    .RESET (RESET),
    .LOAD  (state_q == LOAD),
    .STEP  (state_q == FILL),
    .X_MIN (x_min),
    .X_MAX (x_max),
    .Y_MIN (y_min),
    .Y_MAX (y_max),
    .CUR_X (cur_x),
    .CUR_Y (cur_y),
    .LAST  (last_px)
  );

  // Register bank: coordinate and colour writes are accepted in any state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      colour_q <= 1'b0;
    end else if (reg_wr) begin
      case (offset[2:0])
        REG_X0:   x0_q     <= BUS_DATA;
        REG_Y0:   y0_q     <= BUS_DATA;
        REG_X1:   x1_q     <= BUS_DATA;
        REG_Y1:   y1_q     <= BUS_DATA;
        REG_CTRL: colour_q <= BUS_DATA[CTRL_COLOUR];
        default:  ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; abort overrides both a start and the final pixel
  always_comb begin
    state_d  = state_q;
    done_set = 1'b0;
    case (state_q)
      IDLE: if (start_req) state_d = LOAD;
      LOAD: state_d = abort_req ? IDLE : FILL;
      FILL: begin
        if (abort_req) begin
          state_d = IDLE;
        end else if (last_px) begin
          state_d  = IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fill colour snapshot and sticky DONE flag
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fill_colour_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      if (state_q == LOAD)                 fill_colour_q <= colour_q;
      if (state_q == IDLE && start_req)    done_q        <= 1'b0;
      else if (done_set)                   done_q        <= 1'b1;
    end
  end

  // Registered read path: data appears on the cycle after the address
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_en_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_en_q <= rd_sel;
      case (offset[2:0])
        REG_X0:     rd_data_q <= x0_q;
        REG_Y0:     rd_data_q <= y0_q;
        REG_X1:     rd_data_q <= x1_q;
        REG_Y1:     rd_data_q <= y1_q;
        REG_CTRL:   rd_data_q <= {7'b0, colour_q};
        REG_STATUS: rd_data_q <= {6'b0, done_q, BUSY};
        default:    rd_data_q <= '0;
      endcase
    end
  end

`ifdef VGA_FILL_IRQ_EN
  logic raise_q;

  assign BUS_INTERRUPT_RAISE = raise_q;

  // Completion interrupt; an acknowledge beats a simultaneous raise
  always_ff @(posedge CLK) begin
    if (RESET)                  raise_q <= 1'b0;
    else if (BUS_INTERRUPT_ACK) raise_q <= 1'b0;
    else if (done_set)          raise_q <= 1'b1;
  end
`endif

endmodule
